// File: rtl/dtcm.sv
// Data tightly-coupled memory: single-cycle load/store port with byte lanes,
// a post-reset zero-fill sequencer and a sticky access-error recorder.
module dtcm #(
    parameter int               XLEN        = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0]  BASE_ADR    = 32'h0001_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    input  logic            init_req_i,
    output logic            init_busy_q_o,
    input  logic            err_clr_i,
    output logic            err_q_o,
    output logic [XLEN-1:0] err_adr_q_o,
    output logic [7:0]      err_cnt_q_o
);

    localparam int              AW   = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH_WORDS * 4);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   idx_r;
    logic [AW-1:0]   idx_nxt_s;
    logic            busy_r;

    logic [31:0]     mem_r [DEPTH_WORDS];

    logic [XLEN-1:0] offset_s;
    logic            hit_s;
    logic            misaligned_s;
    logic            ready_s;
    logic            err_acc_s;
    logic            ok_s;
    logic            we_s;
    logic [AW-1:0]   widx_s;
    logic [3:0]      be_s;
    logic [31:0]     wdata_s;
    logic [31:0]     rdata_s;
    logic [31:0]     load_sel_s;

    logic            err_r;
    logic [XLEN-1:0] err_adr_r;
    logic [7:0]      err_cnt_r;

    // Address decode and access classification
    always_comb begin
        offset_s  = adr_i - BASE_ADR;
        // Addresses below the base wrap to large offsets, so one compare covers both ends
        hit_s     = (offset_s < SPAN);
        widx_s    = offset_s[AW+1:2];
        ready_s   = (state_r == READY);
        err_acc_s = adr_v_i & ready_s & (~hit_s | misaligned_s);
        ok_s      = adr_v_i & ready_s & hit_s & ~misaligned_s;
        we_s      = ok_s & is_store_i;
    end

    // Size/alignment check; any non-one-hot size is treated as misaligned
    always_comb begin
        misaligned_s = 1'b1;
        case (access_size_i)
            3'b001:  misaligned_s = 1'b0;
            3'b010:  misaligned_s = adr_i[0];
            3'b100:  misaligned_s = (adr_i[1:0] != 2'b00);
            default: misaligned_s = 1'b1;
        endcase
    end

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = store_data_i[31:0];
        case (access_size_i)
            3'b001: begin
                be_s    = 4'b0001 << adr_i[1:0];
                wdata_s = {4{store_data_i[7:0]}};
            end
            3'b010: begin
                be_s    = adr_i[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{store_data_i[15:0]}};
            end
            3'b100: begin
                be_s    = 4'b1111;
                wdata_s = store_data_i[31:0];
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = store_data_i[31:0];
            end
        endcase
    end

    // Read lane selection, right-aligned and zero-extended
    always_comb begin
        rdata_s    = mem_r[widx_s];
        load_sel_s = 32'h0000_0000;
        case (access_size_i)
            3'b001: begin
                case (adr_i[1:0])
                    2'b00:   load_sel_s = {24'h00_0000, rdata_s[7:0]};
                    2'b01:   load_sel_s = {24'h00_0000, rdata_s[15:8]};
                    2'b10:   load_sel_s = {24'h00_0000, rdata_s[23:16]};
                    default: load_sel_s = {24'h00_0000, rdata_s[31:24]};
                endcase
            end
            3'b010: begin
                if (adr_i[1]) begin
                    load_sel_s = {16'h0000, rdata_s[31:16]};
                end else begin
                    load_sel_s = {16'h0000, rdata_s[15:0]};
                end
            end
            3'b100:  load_sel_s = rdata_s;
            default: load_sel_s = 32'h0000_0000;
        endcase
    end

    // Load data is only driven for a valid, error-free load while READY
    always_comb begin
        if (ok_s && !is_store_i) begin
            load_data_o = XLEN'(load_sel_s);
        end else begin
            load_data_o = '0;
        end
    end

    // Fill sequencer next-state logic
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            CLEAR: begin
                if (init_req_i) begin
                    state_nxt_s = CLEAR;
                    idx_nxt_s   = '0;
                end else if (idx_r == AW'(DEPTH_WORDS - 1)) begin
                    state_nxt_s = READY;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = CLEAR;
                    idx_nxt_s   = idx_r + AW'(1);
                end
            end
            READY: begin
                if (init_req_i) begin
                    state_nxt_s = CLEAR;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = READY;
                    idx_nxt_s   = idx_r;
                end
            end
            default: begin
                state_nxt_s = CLEAR;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Fill sequencer state, index and busy flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= CLEAR;
            idx_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            busy_r  <= (state_nxt_s == CLEAR);
        end
    end

    // Storage array: the fill has priority, core writes only land while READY
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem_r[idx_r] <= 32'h0000_0000;
        end else if (we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Sticky error record; a new error in the clear cycle restarts the record
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r     <= 1'b0;
            err_adr_r <= '0;
            err_cnt_r <= 8'd0;
        end else if (err_acc_s) begin
            err_r <= 1'b1;
            if (!err_r || err_clr_i) begin
                err_adr_r <= adr_i;
            end else begin
                err_adr_r <= err_adr_r;
            end
            if (err_clr_i) begin
                err_cnt_r <= 8'd1;
            end else if (err_cnt_r != 8'd255) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else if (err_clr_i) begin
            err_r     <= 1'b0;
            err_adr_r <= '0;
            err_cnt_r <= 8'd0;
        end else begin
            err_r     <= err_r;
            err_adr_r <= err_adr_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    assign init_busy_q_o = busy_r;
    assign err_q_o       = err_r;
    assign err_adr_q_o   = err_adr_r;
    assign err_cnt_q_o   = err_cnt_r;

endmodule
